// File: rtl/dsm_cic_decimator.sv
// dsm_cic_decimator: CIC decimator that turns a 1-bit delta-sigma stream into signed samples.
// Ports: i_clk, i_rst (sync, active high), i_en/i_bitstream (bit in), o_data/o_valid (sample out).
module dsm_cic_decimator #(
  parameter int DATA_WIDTH  = 16,
  parameter int DECIM_RATIO = 64,
  parameter int ORDER       = 3
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic                         i_bitstream,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_valid
);

  localparam int LOG2R     = $clog2(DECIM_RATIO);
  localparam int ACC_WIDTH = ORDER * LOG2R + 2;
  localparam int SHIFT     = ORDER * LOG2R - (DATA_WIDTH - 1);
  localparam int PW        = (ORDER > 1) ? $clog2(ORDER) : 1;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  localparam acc_t SAT_HI = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}},
                             {(DATA_WIDTH-1){1'b1}}};
  localparam acc_t SAT_LO = ~SAT_HI;

  acc_t             integ     [ORDER];
  acc_t             integ_nxt [ORDER];
  acc_t             dly       [ORDER];
  acc_t             comb      [ORDER+1];
  acc_t             x;
  acc_t             samp;
  acc_t             scaled;
  logic [LOG2R-1:0] cnt;
  logic [PW-1:0]    prime_cnt;
  logic             primed;
  logic             comb_go;
  logic             capture;
  logic signed [DATA_WIDTH-1:0] sat;

  assign x       = i_bitstream ? acc_t'(1) : '1;
  assign capture = i_en && (&cnt);

  // Integrators ripple within the cycle so the capture sees this bit.
  always_comb begin
    integ_nxt[0] = integ[0] + x;
    for (int k = 1; k < ORDER; k++) begin
      integ_nxt[k] = integ[k] + integ_nxt[k-1];
    end
  end

  always_comb begin
    comb[0] = samp;
    for (int k = 0; k < ORDER; k++) begin
      comb[k+1] = comb[k] - dly[k];
    end
  end

  always_comb begin
    scaled = comb[ORDER] >>> SHIFT;
    if (scaled > SAT_HI) begin
      sat = SAT_HI[DATA_WIDTH-1:0];
    end else if (scaled < SAT_LO) begin
      sat = SAT_LO[DATA_WIDTH-1:0];
    end else begin
      sat = scaled[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < ORDER; k++) begin
        integ[k] <= '0;
        dly[k]   <= '0;
      end
      samp      <= '0;
      cnt       <= '0;
      prime_cnt <= '0;
      primed    <= 1'b0;
      comb_go   <= 1'b0;
      o_data    <= '0;
      o_valid   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      comb_go <= capture;
      if (i_en) begin
        integ <= integ_nxt;
        cnt   <= cnt + 1'b1;
      end
      if (capture) begin
        samp <= integ_nxt[ORDER-1];
      end
      if (comb_go) begin
        for (int k = 0; k < ORDER; k++) begin
          dly[k] <= comb[k];
        end
        // The first ORDER outputs still carry start-up transient.
        if (primed) begin
          o_valid <= 1'b1;
          o_data  <= sat;
        end else if (prime_cnt == PW'(ORDER - 1)) begin
          primed <= 1'b1;
        end else begin
          prime_cnt <= prime_cnt + 1'b1;
        end
      end
    end
  end

endmodule
